// File: rtl/spi_shift_engine_if.sv
// Bundle between the SPI register block, the shift engine and the SPI pins.
// master = shift engine side, slave = register block / pin environment side.
interface spi_shift_engine_if #(
  parameter int unsigned DATA_BITS = 32
);
  logic                 start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 busy;
  logic                 done;
  logic [DATA_BITS-1:0] rx_data;
  logic                 sclk;
  logic                 mosi;
  logic                 miso;
  logic                 ss_n;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, ss_n
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0, MSB-first full-duplex SPI shift engine with start/done handshake.
// Optional SPI_SHIFT_LOOPBACK_EN: receive path samples mosi instead of miso.
module spi_shift_engine #(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic               clk,
  input  logic               reset,
  spi_shift_engine_if.master bus
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_BITS);
  localparam int unsigned TX_W  = DATA_BITS - 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TX_W-1:0]      tx_q, tx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 ss_n_q, ss_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rx_bit;
  logic                 div_last;

`ifdef SPI_SHIFT_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = bus.miso;
  assign rx_bit      = mosi_q;
`else
  assign rx_bit      = bus.miso;
`endif

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    sh_d      = sh_q;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          tx_d    = bus.tx_data[DATA_BITS-2:0];
          mosi_d  = bus.tx_data[DATA_BITS-1];
          ss_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          cnt_d   = '0;
          sh_d    = '0;
        end
      end
      SETUP: begin
        if (div_last) begin
          // First rising sclk edge; miso captured in the same cycle
          div_d   = '0;
          state_d = SHIFT;
          sclk_d  = 1'b1;
          sh_d    = {sh_q[DATA_BITS-2:0], rx_bit};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT: begin
        if (div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            sh_d = {sh_q[DATA_BITS-2:0], rx_bit};
          end else if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            // Last falling edge: mosi holds through HOLD
            state_d = HOLD;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            mosi_d = tx_q[TX_W-1];
            tx_d   = tx_q << 1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      HOLD: begin
        if (div_last) begin
          div_d     = '0;
          state_d   = IDLE;
          ss_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = sh_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      sh_q      <= '0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      sh_q      <= sh_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_n_q    <= ss_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Scoreboard bench: dut_a (32 bits, CLK_DIV=4) and dut_b (8 bits, CLK_DIV=1).
// Inputs driven on negedge; monitors sample 1 time unit after posedge.
module tb_spi_shift_engine;

  typedef struct {
    logic [31:0] rx;
    logic [31:0] tx;
    int unsigned done_cyc;
    int unsigned low;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  spi_shift_engine_if #(.DATA_BITS(32)) a_if ();
  spi_shift_engine_if #(.DATA_BITS(8))  b_if ();

  spi_shift_engine #(.DATA_BITS(32), .CLK_DIV(4)) dut_a (
    .clk(clk), .reset(rst_a), .bus(a_if.master)
  );
  spi_shift_engine #(.DATA_BITS(8), .CLK_DIV(1)) dut_b (
    .clk(clk), .reset(rst_b), .bus(b_if.master)
  );

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + slave model for dut_a
  logic [31:0] a_slave = '0;
  logic [31:0] a_mcap = '0;
  int          a_edges = 0;
  int          a_rcnt = 0;
  int unsigned a_low_start = 0;
  int          a_done_cnt = 0;
  bit          a_prev_ss = 1'b1;
  bit          a_prev_sclk = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!a_if.ss_n && a_prev_ss) begin
      a_edges = 0; a_mcap = '0; a_low_start = cyc;
    end
    if (a_if.sclk && !a_prev_sclk) begin
      a_edges++; a_mcap = {a_mcap[30:0], a_if.mosi};
    end
    if (a_if.ss_n) a_rcnt = 0;
    else if (!a_if.sclk && a_prev_sclk) a_rcnt++;
    a_if.miso = (a_rcnt < 32) ? a_slave[31-a_rcnt] : 1'b0;
    if (a_if.done) begin
      a_done_cnt++;
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = q_a.pop_front();
        check("a_rx_data", a_if.rx_data, e.rx);
        check("a_mosi_stream", a_mcap, e.tx);
        check("a_done_cycle", cyc, e.done_cyc);
        check("a_sclk_rises", 32'(a_edges), 32'd32);
        check("a_ss_low_cycles", cyc - a_low_start, e.low);
        check("a_busy_at_done", 32'(a_if.busy), 32'd0);
        check("a_ss_n_at_done", 32'(a_if.ss_n), 32'd1);
      end
    end
    a_prev_ss = a_if.ss_n;
    a_prev_sclk = a_if.sclk;
  end

  // Monitor + slave model for dut_b
  logic [7:0]  b_slave = '0;
  logic [7:0]  b_mcap = '0;
  int          b_edges = 0;
  int          b_rcnt = 0;
  int unsigned b_low_start = 0;
  int unsigned b_rise_cyc = 0;
  int unsigned b_gap = 0;
  int          b_done_cnt = 0;
  bit          b_prev_ss = 1'b1;
  bit          b_prev_sclk = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (a_if.ss_n === 1'bx) ;
    if (b_if.ss_n && !b_prev_ss) b_rise_cyc = cyc;
    if (!b_if.ss_n && b_prev_ss) begin
      b_gap = cyc - b_rise_cyc;
      b_edges = 0; b_mcap = '0; b_low_start = cyc;
    end
    if (b_if.sclk && !b_prev_sclk) begin
      b_edges++; b_mcap = {b_mcap[6:0], b_if.mosi};
    end
    if (b_if.ss_n) b_rcnt = 0;
    else if (!b_if.sclk && b_prev_sclk) b_rcnt++;
    b_if.miso = (b_rcnt < 8) ? b_slave[7-b_rcnt] : 1'b0;
    if (b_if.done) begin
      b_done_cnt++;
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = q_b.pop_front();
        check("b_rx_data", 32'(b_if.rx_data), e.rx);
        check("b_mosi_stream", 32'(b_mcap), e.tx);
        check("b_done_cycle", cyc, e.done_cyc);
        check("b_sclk_rises", 32'(b_edges), 32'd8);
        check("b_ss_low_cycles", cyc - b_low_start, e.low);
        check("b_busy_at_done", 32'(b_if.busy), 32'd0);
      end
    end
    b_prev_ss = b_if.ss_n;
    b_prev_sclk = b_if.sclk;
  end

  task automatic wait_done(input bit sel_b, input int budget, input string name);
    int n;
    n = sel_b ? b_done_cnt : a_done_cnt;
    for (int i = 0; i < budget; i++) begin
      if ((sel_b ? b_done_cnt : a_done_cnt) != n) break;
      @(negedge clk);
    end
    checks++;
    if ((sel_b ? b_done_cnt : a_done_cnt) == n) begin
      errors++;
      $display("FAIL %s: got no done within %0d cycles, expected done", name, budget);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] tx, input logic [31:0] slv,
                              input int unsigned dc, input int unsigned low);
    exp_t e;
`ifdef SPI_SHIFT_LOOPBACK_EN
    e.rx = tx;
`else
    e.rx = slv;
`endif
    e.tx = tx;
    e.done_cyc = dc;
    e.low = low;
    return e;
  endfunction

  // Start dut_a transfer in the current cycle (T0 = cyc); done expected at T0+261
  task automatic start_a(input logic [31:0] tx, input logic [31:0] slv, output int unsigned t0);
    t0 = cyc;
    a_slave = slv;
    a_if.start = 1'b1;
    a_if.tx_data = tx;
    q_a.push_back(mk(tx, slv, t0 + 261, 260));
    @(negedge clk);
    a_if.start = 1'b0;
    a_if.tx_data = 32'h0;
  endtask

  initial begin
    int unsigned t0;
    int n;
    a_if.start = 1'b0; a_if.tx_data = '0; a_if.miso = 1'b0;
    b_if.start = 1'b0; b_if.tx_data = '0; b_if.miso = 1'b0;

    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    check("rst_sclk", 32'(a_if.sclk), 32'd0);
    check("rst_ss_n", 32'(a_if.ss_n), 32'd1);
    check("rst_mosi", 32'(a_if.mosi), 32'd0);
    check("rst_busy", 32'(a_if.busy), 32'd0);
    check("rst_done", 32'(a_if.done), 32'd0);
    check("rst_rx_data", a_if.rx_data, 32'd0);

    // Basic transfer
    start_a(32'hA5A50F0F, 32'h3CC3F00F, t0);
    check("a_busy_after_start", 32'(a_if.busy), 32'd1);
    wait_done(1'b0, 400, "a_basic_timeout");

    // Busy rejection: second start at T0+50 ignored
    @(negedge clk);
    start_a(32'hA5A50F0F, 32'h3CC3F00F, t0);
    while (cyc < t0 + 50) @(negedge clk);
    check("a_busy_mid", 32'(a_if.busy), 32'd1);
    a_if.start = 1'b1;
    a_if.tx_data = 32'hFFFFFFFF;
    @(negedge clk);
    a_if.start = 1'b0;
    wait_done(1'b0, 400, "a_reject_timeout");
    repeat (20) @(negedge clk);
    check("a_no_queued_start", 32'(a_if.busy), 32'd0);

    // Reset mid-transfer
    start_a(32'h12345678, 32'hCAFEBABE, t0);
    void'(q_a.pop_back());
    while (cyc < t0 + 100) @(negedge clk);
    check("a_ss_n_before_abort", 32'(a_if.ss_n), 32'd0);
    n = a_done_cnt;
    rst_a = 1'b1;
    #1;
    check("abort_ss_n", 32'(a_if.ss_n), 32'd1);
    check("abort_sclk", 32'(a_if.sclk), 32'd0);
    check("abort_busy", 32'(a_if.busy), 32'd0);
    check("abort_mosi", 32'(a_if.mosi), 32'd0);
    check("abort_rx_data", a_if.rx_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (300) @(negedge clk);
    check("abort_no_done", 32'(a_done_cnt), 32'(n));
    check("abort_rx_kept_zero", a_if.rx_data, 32'd0);

    // Normal transfer after abort (also the loopback vector)
    start_a(32'h12345678, 32'h0F1E2D3C, t0);
    wait_done(1'b0, 400, "a_after_abort_timeout");

    // Back-to-back on dut_b with start held high
    @(negedge clk);
    t0 = cyc;
    b_slave = 8'h5C;
    b_if.start = 1'b1;
    b_if.tx_data = 8'h81;
    q_b.push_back(mk(32'h81, 32'h5C, t0 + 18, 17));
    @(negedge clk);
    b_if.tx_data = 8'h7E;
    wait_done(1'b1, 40, "b_first_timeout");
    t0 = cyc;
    b_slave = 8'hA3;
    q_b.push_back(mk(32'h7E, 32'hA3, t0 + 18, 17));
    @(negedge clk);
    b_if.start = 1'b0;
    check("b_second_accepted", 32'(b_if.busy), 32'd1);
    wait_done(1'b1, 40, "b_second_timeout");
    check("b_ss_n_gap", b_gap, 32'd1);

    repeat (10) @(negedge clk);
    check("a_queue_drained", 32'(q_a.size()), 32'd0);
    check("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
